// File: rtl/dac_spi_out.sv
// dac_spi_out: serialises 16-bit DDS samples onto a 3-wire SPI DAC.
// SPI mode 0 (SCLK idles low, data changes on falling edges), MSB first.
// A free-running tick counter (while en=1) starts one frame per
// SAMPLE_DIV cycles. A tick that arrives while a frame is running is
// dropped and raises the sticky overrun flag.
// Optional build macro: DAC_OFFSET_BIN_EN inverts sig_in[15] at capture
// (two's complement -> offset binary).
module dac_spi_out #(
    parameter int CLK_DIV    = 2,
    parameter int SAMPLE_DIV = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sig_in,
    input  logic        en,
    output logic        dac_sclk,
    output logic        dac_cs_n,
    output logic        dac_din,
    output logic        busy,
    output logic        done,
    output logic        overrun
);
    localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [3:0]    bcnt_q, bcnt_d;
    logic [15:0]   sreg_q, sreg_d;
    logic          sclk_q, sclk_d;
    logic          cs_n_q, cs_n_d;
    logic          din_q, din_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ovr_q, ovr_d;
    logic          tick;
    logic          half_end;
    logic [15:0]   cap;

    // Sample-rate tick: counter held at zero while disabled
    always_comb begin
        tick   = en && (tcnt_q == TW'(SAMPLE_DIV - 1));
        tcnt_d = tcnt_q + TW'(1);
        if (!en || tick) tcnt_d = '0;
    end

    // Word captured at frame start, optionally converted to offset binary
    always_comb begin
        cap = sig_in;
`ifdef DAC_OFFSET_BIN_EN
        cap[15] = ~sig_in[15];
`else
`endif
    end

    // Frame sequencing: next state and next registered outputs
    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        bcnt_d   = bcnt_q;
        sreg_d   = sreg_q;
        sclk_d   = sclk_q;
        cs_n_d   = cs_n_q;
        din_d    = din_q;
        done_d   = 1'b0;
        ovr_d    = ovr_q | (tick && (state_q != IDLE));
        half_end = (hcnt_q == HW'(CLK_DIV - 1));
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SHIFT;
                    sreg_d  = cap;
                    cs_n_d  = 1'b0;
                    din_d   = cap[15];
                    sclk_d  = 1'b0;
                    hcnt_d  = '0;
                    bcnt_d  = 4'd15;
                end
            end
            SHIFT: begin
                if (half_end) begin
                    hcnt_d = '0;
                    sclk_d = ~sclk_q;
                    // Falling edge: advance to the next bit or close the frame
                    if (sclk_q) begin
                        if (bcnt_q != 4'd0) begin
                            sreg_d = {sreg_q[14:0], 1'b0};
                            din_d  = sreg_q[14];
                            bcnt_d = bcnt_q - 4'd1;
                        end else begin
                            state_d = HOLD;
                            cs_n_d  = 1'b1;
                            din_d   = 1'b0;
                        end
                    end
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            HOLD: begin
                if (half_end) begin
                    hcnt_d  = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            hcnt_q  <= '0;
            bcnt_q  <= '0;
            sreg_q  <= '0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            din_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            hcnt_q  <= hcnt_d;
            bcnt_q  <= bcnt_d;
            sreg_q  <= sreg_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dac_sclk = sclk_q;
    assign dac_cs_n = cs_n_q;
    assign dac_din  = din_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overrun  = ovr_q;
endmodule

// File: tb/tb_dac_spi_out.sv
// Bench for dac_spi_out: three instances (defaults, overrun-prone timing,
// CLK_DIV=1) each with their own reset/enable/sample, checked by directed
// scenarios against hand-derived frame timing.
module tb_dac_spi_out;
    logic            clk;
    logic [2:0]      rst;
    logic [2:0]      en;
    logic [2:0][15:0] sig;
    wire  [2:0]      sclk, cs_n, din, busy, done, ovr;

    int tests = 0;
    int fails = 0;

    dac_spi_out u_dut (
        .clk(clk), .rst(rst[0]), .sig_in(sig[0]), .en(en[0]),
        .dac_sclk(sclk[0]), .dac_cs_n(cs_n[0]), .dac_din(din[0]),
        .busy(busy[0]), .done(done[0]), .overrun(ovr[0]));

    dac_spi_out #(.CLK_DIV(2), .SAMPLE_DIV(40)) u_ovr (
        .clk(clk), .rst(rst[1]), .sig_in(sig[1]), .en(en[1]),
        .dac_sclk(sclk[1]), .dac_cs_n(cs_n[1]), .dac_din(din[1]),
        .busy(busy[1]), .done(done[1]), .overrun(ovr[1]));

    dac_spi_out #(.CLK_DIV(1), .SAMPLE_DIV(40)) u_cd1 (
        .clk(clk), .rst(rst[2]), .sig_in(sig[2]), .en(en[2]),
        .dac_sclk(sclk[2]), .dac_cs_n(cs_n[2]), .dac_din(din[2]),
        .busy(busy[2]), .done(done[2]), .overrun(ovr[2]));

    always #5 clk = ~clk;

    // Word the DAC is expected to receive for a given sample
    function automatic logic [15:0] expv(input logic [15:0] v);
`ifdef DAC_OFFSET_BIN_EN
        return v ^ 16'h8000;
`else
        return v;
`endif
    endfunction

    // Waits (bounded) for CS_N low, then records one frame. Called at a negedge.
    task automatic receive(input int id, input int cd, input int drop_after,
                           output int wait_n, output logic [15:0] data,
                           output int rises, output int cs_low,
                           output int dones, output int done_off, output bit tmo);
        logic prev;
        int k;
        tmo = 0; wait_n = 0; data = '0; rises = 0; cs_low = 0; dones = 0; done_off = -1;
        while (cs_n[id] !== 1'b0 && wait_n < 1000) begin
            @(negedge clk); wait_n++;
        end
        if (wait_n >= 1000) begin tmo = 1; return; end
        prev = sclk[id];
        k = 0;
        while (cs_n[id] === 1'b0 && k < 2000) begin
            cs_low++;
            if (sclk[id] && !prev) begin data = {data[14:0], din[id]}; rises++; end
            prev = sclk[id];
            if (done[id]) dones++;
            if (drop_after > 0 && k == drop_after) en[id] = 1'b0;
            @(negedge clk); k++;
        end
        if (k >= 2000) tmo = 1;
        for (int j = 0; j <= cd + 3; j++) begin
            if (done[id]) begin dones++; if (done_off < 0) done_off = j; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int sclk_seen;
        logic [5:0] o;
        sclk_seen = 0;
        rst = 3'b111; en = 3'b111;
        repeat (5) begin
            @(negedge clk);
            if (sclk[0]) sclk_seen++;
        end
        o = {sclk[0], cs_n[0], din[0], busy[0], done[0], ovr[0]};
        tests++;
        if (o !== 6'b010000) begin fails++; $display("FAIL reset_outputs got %b exp 010000", o); end
        tests++;
        if (sclk_seen !== 0) begin fails++; $display("FAIL reset_sclk_activity got %0d exp 0", sclk_seen); end
    endtask

    task automatic test_single_frame;
        int w, r, cl, d, off; logic [15:0] v; bit t;
        sig[0] = 16'hA5C3;
        rst[0] = 1'b0;
        receive(0, 2, 0, w, v, r, cl, d, off, t);
        tests++; if (t !== 1'b0) begin fails++; $display("FAIL single_timeout got %0d exp 0", t); end
        tests++; if (w !== 100) begin fails++; $display("FAIL single_first_tick got %0d exp 100", w); end
        tests++; if (v !== expv(16'hA5C3)) begin fails++; $display("FAIL single_data got %h exp %h", v, expv(16'hA5C3)); end
        tests++; if (r !== 16) begin fails++; $display("FAIL single_rises got %0d exp 16", r); end
        tests++; if (cl !== 64) begin fails++; $display("FAIL single_cs_low got %0d exp 64", cl); end
        tests++; if (d !== 1) begin fails++; $display("FAIL single_done_count got %0d exp 1", d); end
        tests++; if (off !== 2) begin fails++; $display("FAIL single_done_offset got %0d exp 2", off); end
        tests++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL single_busy_after got %b exp 0", busy[0]); end
    endtask

    task automatic test_disable;
        int w, r, cl, d, off, falls, n; logic [15:0] v; bit t;
        sig[0] = 16'h3C5A;
        receive(0, 2, 10, w, v, r, cl, d, off, t);
        tests++; if (v !== expv(16'h3C5A) || t) begin fails++; $display("FAIL disable_data got %h exp %h", v, expv(16'h3C5A)); end
        tests++; if (r !== 16) begin fails++; $display("FAIL disable_rises got %0d exp 16", r); end
        falls = 0;
        repeat (300) begin
            @(negedge clk);
            if (cs_n[0] === 1'b0) falls++;
        end
        tests++; if (falls !== 0) begin fails++; $display("FAIL disable_no_frame got %0d exp 0", falls); end
        sig[0] = 16'h0F0F;
        en[0] = 1'b1;
        n = 0;
        while (cs_n[0] !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
        tests++; if (n !== 100) begin fails++; $display("FAIL reenable_tick got %0d exp 100", n); end
        receive(0, 2, 0, w, v, r, cl, d, off, t);
        tests++; if (v !== expv(16'h0F0F) || t) begin fails++; $display("FAIL reenable_data got %h exp %h", v, expv(16'h0F0F)); end
    endtask

    task automatic test_reset_mid;
        int w, r, cl, d, off, n, rs; logic [15:0] v; bit t; logic prev; logic [4:0] o;
        sig[0] = 16'hFFFF;
        n = 0;
        while (cs_n[0] !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
        rs = 0; prev = sclk[0];
        while (rs < 7 && n < 2000) begin
            @(negedge clk); n++;
            if (sclk[0] && !prev) rs++;
            prev = sclk[0];
        end
        tests++; if (rs !== 7) begin fails++; $display("FAIL rstmid_reach7 got %0d exp 7", rs); end
        rst[0] = 1'b1;
        @(negedge clk);
        o = {cs_n[0], sclk[0], busy[0], ovr[0], done[0]};
        tests++; if (o !== 5'b10000) begin fails++; $display("FAIL rstmid_outputs got %b exp 10000", o); end
        rst[0] = 1'b0;
        sig[0] = 16'h8001;
        receive(0, 2, 0, w, v, r, cl, d, off, t);
        tests++; if (w !== 100) begin fails++; $display("FAIL rstmid_restart got %0d exp 100", w); end
        tests++; if (v !== expv(16'h8001) || r !== 16 || t) begin fails++; $display("FAIL rstmid_data got %h/%0d exp %h/16", v, r, expv(16'h8001)); end
    endtask

    task automatic test_overrun;
        int w, r, cl, d, off, n; logic [15:0] v; bit t;
        sig[1] = 16'h1234;
        rst[1] = 1'b0;
        n = 0;
        while (cs_n[1] !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
        tests++; if (ovr[1] !== 1'b0) begin fails++; $display("FAIL ovr_initially got %b exp 0", ovr[1]); end
        sig[1] = 16'hDEAD;
        receive(1, 2, 0, w, v, r, cl, d, off, t);
        tests++; if (v !== expv(16'h1234) || t) begin fails++; $display("FAIL ovr_frame1 got %h exp %h", v, expv(16'h1234)); end
        tests++; if (ovr[1] !== 1'b1) begin fails++; $display("FAIL ovr_set got %b exp 1", ovr[1]); end
        sig[1] = 16'hBEEF;
        receive(1, 2, 0, w, v, r, cl, d, off, t);
        tests++; if (v !== expv(16'hBEEF) || t) begin fails++; $display("FAIL ovr_frame3 got %h exp %h", v, expv(16'hBEEF)); end
        tests++; if (ovr[1] !== 1'b1) begin fails++; $display("FAIL ovr_sticky got %b exp 1", ovr[1]); end
    endtask

    task automatic test_clkdiv1;
        int w, r, cl, d, off; logic [15:0] v; bit t;
        sig[2] = 16'h0001;
        rst[2] = 1'b0;
        receive(2, 1, 0, w, v, r, cl, d, off, t);
        tests++; if (w !== 40 || t) begin fails++; $display("FAIL cd1_first_tick got %0d exp 40", w); end
        tests++; if (v !== expv(16'h0001)) begin fails++; $display("FAIL cd1_data got %h exp %h", v, expv(16'h0001)); end
        tests++; if (v[0] !== 1'b1) begin fails++; $display("FAIL cd1_last_bit got %b exp 1", v[0]); end
        tests++; if (r !== 16) begin fails++; $display("FAIL cd1_rises got %0d exp 16", r); end
        tests++; if (cl !== 32) begin fails++; $display("FAIL cd1_cs_low got %0d exp 32", cl); end
        tests++; if (d !== 1 || off !== 1) begin fails++; $display("FAIL cd1_done got %0d@%0d exp 1@1", d, off); end
    endtask

    initial begin
        clk = 1'b0;
        rst = 3'b111;
        en  = 3'b111;
        sig = '0;
        test_reset();
        test_single_frame();
        test_disable();
        test_reset_mid();
        test_overrun();
        test_clkdiv1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
